// File: rtl/rule_truth_table_sweeper.sv
// rule_truth_table_sweeper
// Characterises a 3-input rule block. The sweeper drives {in1,in2,in3} through
// 000..111 and holds each combination for a settle window. It then takes a
// majority vote over several samples of the block's out and builds the 8-bit
// rule word, which it compares against an expected code.
//
// Handshake: start is a level that is accepted only in IDLE, on the edge that
// sees it high. abort (when start is not also accepted) cancels a running
// sweep on the next edge. done is a single-cycle pulse in FINISH, and
// rule_word/match are already valid in that cycle.
module rule_truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLES       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] rule_word,
    output logic       match,
    output logic [1:0] dbg_state
);

    localparam int            CW          = $clog2(SAMPLES + 1);
    localparam int            HALF        = SAMPLES / 2;
    localparam logic [7:0]    SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLES - 1);
    localparam logic [CW-1:0] VOTE_HALF   = CW'(HALF);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [2:0]    r_idx;
    logic [7:0]    r_settle;
    logic [CW-1:0] r_scnt;
    logic [CW-1:0] r_ones;
    logic [7:0]    r_shadow;
    logic [7:0]    r_exp;
    logic [7:0]    r_rule_word;
    logic          r_match;

    logic [CW-1:0] w_ones_sum;
    logic          w_vote;
    logic          w_last_sample;
    logic          w_accept;
    logic [7:0]    w_shadow_next;

    // The vote includes the sample taken on the current edge.
    assign w_ones_sum    = r_ones + CW'(dut_out);
    assign w_vote        = (w_ones_sum > VOTE_HALF);
    assign w_last_sample = (r_state == S_SAMPLE) && (r_scnt == SAMPLE_LAST);
    assign w_accept      = (r_state == S_IDLE) && start && !abort;

    // Shadow word with the current combination's voted bit merged in.
    always_comb begin
        w_shadow_next = r_shadow;
        w_shadow_next[3'd7 - r_idx] = w_vote;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (r_settle == 8'd0) begin
                    w_state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                busy = 1'b1;
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_last_sample) begin
                    w_state_next = (r_idx == 3'd7) ? S_FINISH : S_SETTLE;
                end
            end
            S_FINISH: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: combination index, settle/sample counters, vote and results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= 3'd0;
            r_settle    <= 8'd0;
            r_scnt      <= '0;
            r_ones      <= '0;
            r_shadow    <= 8'h00;
            r_exp       <= 8'h00;
            r_rule_word <= 8'h00;
            r_match     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idx <= 3'd0;
                    if (w_accept) begin
                        r_exp    <= expected;
                        r_settle <= SETTLE_LOAD;
                        r_scnt   <= '0;
                        r_ones   <= '0;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        r_idx <= 3'd0;
                    end else if (r_settle != 8'd0) begin
                        r_settle <= r_settle - 8'd1;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        r_idx  <= 3'd0;
                        r_scnt <= '0;
                        r_ones <= '0;
                    end else if (w_last_sample) begin
                        r_shadow <= w_shadow_next;
                        r_scnt   <= '0;
                        r_ones   <= '0;
                        if (r_idx == 3'd7) begin
                            r_rule_word <= w_shadow_next;
                            r_match     <= (w_shadow_next == r_exp);
                        end else begin
                            r_idx    <= r_idx + 3'd1;
                            r_settle <= SETTLE_LOAD;
                        end
                    end else begin
                        r_scnt <= r_scnt + CW'(1);
                        r_ones <= w_ones_sum;
                    end
                end
                S_FINISH: begin
                    r_idx <= 3'd0;
                end
                default: begin
                    r_idx <= 3'd0;
                end
            endcase
        end
    end

    assign in1       = r_idx[2];
    assign in2       = r_idx[1];
    assign in3       = r_idx[0];
    assign rule_word = r_rule_word;
    assign match     = r_match;
    assign dbg_state = r_state;

endmodule
